// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, a single-outstanding prefetch into a
// one-entry buffer, and the instruction register with its decoded fields.
module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_rst,
    input  logic        pc_write,
    input  logic        pc_sel,
    input  logic        br_sel,
    input  logic        ir_load,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [3:0]  opcode,
    output logic [3:0]  mm,
    output logic [15:0] imm,
    output logic [15:0] pc,
    output logic        fetch_stall
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        stale_q, stale_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] ir_q, ir_d;
    logic [15:0] pc_q, pc_d;

    logic        pc_we;
    logic        pc_chg;
    logic        req_c;

    always_comb begin
        fetch_stall = ir_load && (state_q != S_HOLD);
        pc_we       = pc_write && !fetch_stall;
        pc_chg      = pc_rst || pc_we;
    end

    // Branch offsets/targets come from the instruction already in ir.
    always_comb begin
        pc_d = pc_q;
        if (pc_rst) begin
            pc_d = 16'h0000;
        end else if (pc_we) begin
            if (!pc_sel) begin
                pc_d = pc_q + 16'd1;
            end else if (br_sel) begin
                pc_d = ir_q[15:0];
            end else begin
                pc_d = pc_q + ir_q[15:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        stale_d = stale_q;
        buf_d   = buf_q;
        ir_d    = ir_q;
        req_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Only launch a read once the PC is stable for this cycle.
                if (!pc_chg) begin
                    req_c   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                req_c = 1'b1;
                if (imem_ack) begin
                    stale_d = 1'b0;
                    state_d = S_IDLE;
                    if (!stale_q && !pc_chg) begin
                        buf_d   = imem_rdata;
                        state_d = S_HOLD;
                    end
                end else if (pc_chg) begin
                    stale_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (ir_load) begin
                    ir_d    = buf_q;
                    state_d = S_IDLE;
                end else if (pc_chg) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                stale_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            stale_q <= 1'b0;
            buf_q   <= 32'h0;
            ir_q    <= 32'h0;
            pc_q    <= 16'h0;
        end else begin
            state_q <= state_d;
            stale_q <= stale_d;
            buf_q   <= buf_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
        end
    end

    assign imem_req  = req_c && !rst;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign opcode    = ir_q[31:28];
    assign mm        = ir_q[27:24];
    assign imm       = ir_q[15:0];

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have ports pc_rst, pc_write, pc_sel, br_sel, ir_load, inputs, 1 bit each: control strobes driven by the control FSM.
REQ-004 SHALL have port imem_addr, output, 16 bits: instruction address, always equal to the PC register.
REQ-005 SHALL have port imem_req, output, 1 bit: read request to instruction memory.
REQ-006 SHALL have ports imem_ack (input, 1 bit) and imem_rdata (input, 32 bits): read completion and data, valid only when imem_ack=1.
REQ-007 SHALL have port ir, output, 32 bits: instruction register.
REQ-008 SHALL have ports opcode (ir[31:28]), mm (ir[27:24]) and imm (ir[15:0]), outputs of 4, 4 and 16 bits.
REQ-009 SHALL have port pc, output, 16 bits: current PC value.
REQ-010 SHALL have port fetch_stall, output, 1 bit: ir_load requested but no instruction is buffered.

Function
REQ-011 SHALL implement prefetch FSM states IDLE, REQ and HOLD, plus a 1-bit stale flag and a 32-bit buffer.
REQ-012 IDLE SHALL assert imem_req, then go to REQ next cycle, unless pc_rst or rst is active.
REQ-013 REQ SHALL hold imem_req=1 until imem_ack=1, with 1 to N cycles of memory latency allowed.
REQ-014 On imem_ack in REQ with stale=0, the block SHALL capture imem_rdata into the buffer and go to HOLD, deasserting imem_req in the same edge.
REQ-015 On imem_ack in REQ with stale=1, the block SHALL discard the data, clear stale and go to IDLE, so the new PC is requested next.
REQ-016 A pc_write or pc_rst accepted while in REQ SHALL set stale=1.
REQ-017 HOLD SHALL keep imem_req=0.
REQ-018 In HOLD with ir_load=1, the block SHALL load ir from the buffer and go to IDLE.
REQ-019 In HOLD with pc_write=1 or pc_rst=1 and ir_load=0, the block SHALL discard the buffer and go to IDLE.
REQ-020 fetch_stall SHALL be combinational: ir_load=1 and state not HOLD.
REQ-021 While fetch_stall=1, the block SHALL leave ir unchanged and ignore pc_write; pc_rst is still honoured.
REQ-022 The PC SHALL update on an accepted pc_write as follows: pc_sel=0 gives pc+1; pc_sel=1 with br_sel=0 gives pc+imm (relative); pc_sel=1 with br_sel=1 gives imm (absolute).
REQ-023 All PC arithmetic SHALL be 16-bit modulo: 0xFFFF+1 gives 0x0000, and imm is treated as unsigned with wrap.
REQ-024 pc_rst SHALL synchronously set pc=0x0000 and SHALL take priority over pc_write.
REQ-025 ir_load and pc_write together in HOLD SHALL load ir with the old-PC instruction, update the PC and go to IDLE in one edge.
REQ-026 Branch target imm SHALL be taken from the current ir, not the buffer.
REQ-027 The block SHALL accept no new request while in HOLD: at most one outstanding memory read.

Reset
REQ-028 rst=1 SHALL immediately force pc=0, ir=0, buffer=0, stale=0, state=IDLE and imem_req=0, with fetch_stall following from state.
REQ-029 rst asserted mid-REQ SHALL drop imem_req at once, and any imem_ack arriving while rst=1 SHALL be ignored.
REQ-030 After rst deasserts, the first rising edge SHALL move IDLE to REQ with imem_addr=0x0000.

Verification
REQ-031 Scenario: release rst, memory acks after 3 cycles with 0x8100_0005 -> imem_req high for 3 cycles; state HOLD; ir_load gives ir=0x81000005, opcode=8, mm=1, imm=0x0005.
REQ-032 Scenario: ir_load=1 while in REQ -> fetch_stall=1, ir unchanged, simultaneous pc_write ignored; after ack, ir_load loads correctly.
REQ-033 Scenario: pc=0x0010, ir imm=0x0020, pc_write=1, pc_sel=1, br_sel=0 -> pc=0x0030; with br_sel=1 -> pc=0x0020.
REQ-034 Scenario: pc=0xFFFF, pc_write=1, pc_sel=0 -> pc=0x0000, imem_addr=0x0000.
REQ-035 Scenario: pc_write during REQ for address 0x0004 -> the ack data is discarded, a new request is issued to the new PC, and ir never holds the 0x0004 data.
REQ-036 Scenario: pc_rst=1 and pc_write=1 in the same cycle -> pc=0x0000; async rst mid-REQ -> imem_req=0 before the next clock edge.
